muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised HI/LO multiply-divide unit for the MIPS32 execute stage. It replaces the HILO logic that is currently embedded in the ALU.
- Provides a pipelined multiplier (MULT/MULTU/MADD/MADDU/MSUB/MSUBU), an iterative signed/unsigned divider with configurable bits-per-cycle, and MTHI/MTLO.
- Adds flush-abort, divide-by-zero and overflow-defined results, a completion pulse and a unified stall output.

Parameters:
- WIDTH, 32: operand width. HI and LO are each WIDTH bits. Must be even and ≥8.
- MUL_STAGES, 2: multiply latency in clock edges. Valid range 1..4.
- DIV_BITS, 1: quotient bits retired per divide iteration. Must be 1, 2 or 4, and must divide WIDTH.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. Asserts immediately; deasserts synchronously to clock.
- start  in  1  EX-stage request; op, a and b are valid while start is high.
- op  in  4  0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 DIV, 7 DIVU, 8 MTHI, 9 MTLO; 10–15 are no-ops.
- a  in  WIDTH  rs operand (dividend / MTHI/MTLO source).
- b  in  WIDTH  rt operand (divisor).
- flush  in  1  EX flush/stall-commit kill; aborts an accepted or in-flight operation.
- hilo_read  in  1  EX instruction reads HI/LO (MFHI/MFLO).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  a multiply or divide is in flight.
- stall  out  1  busy & (start | hilo_read).
- done  out  1  one-cycle pulse after HI/LO is written by a mul/div.
- div_by_zero  out  1  one-cycle pulse coincident with done when divisor was 0.

Behaviour:
- Reset (reset=0): hi=0, lo=0, busy=0, done=0, div_by_zero=0, FSM=IDLE. Applies mid-operation; the in-flight result is discarded.
- FSM states and entry conditions:
  - IDLE → MUL: start & ~flush & op∈0..5.
  - IDLE → DIV: start & ~flush & op∈6..7.
  - MTHI/MTLO: write hi=a or lo=a at the accepting edge. Stays in IDLE; no busy, no done.
- Acceptance: start is sampled only in IDLE. start while busy is ignored; stall=1 holds the pipeline until the request is re-presented.
- flush with start in the same cycle: the request is not accepted; HI/LO are unchanged.
- MUL: operands are latched at acceptance edge E0. The full 2*WIDTH product is computed signed (ops 0/2/4) or unsigned (ops 1/3/5).
  - {hi,lo} is written at edge E0+MUL_STAGES:
    - MULT/MULTU: = product.
    - MADD/MADDU: = {hi,lo} + product, mod 2^(2*WIDTH).
    - MSUB/MSUBU: = {hi,lo} − product, mod 2^(2*WIDTH).
  - busy=1 from E0 until the write edge.
- DIV: operands are latched at E0 and converted to magnitudes. N=WIDTH/DIV_BITS restoring iterations run at edges E0+1..E0+N. A sign-fix/writeback occurs at E0+N+1.
  - Result: lo=quotient, hi=remainder.
  - Signed results truncate toward zero; the remainder takes the sign of the dividend.
- Boundary cases:
  - Divisor 0 (signed or unsigned): lo = all ones, hi = a; div_by_zero pulses with done.
  - Signed most-negative / −1: lo = most-negative, hi = 0; no flag.
- done is high for exactly the one cycle following the HI/LO write edge. The FSM returns to IDLE on that write edge, so a new start is accepted during the done cycle.
- flush while busy: the operation aborts at the next edge. busy=0 and HI/LO are unchanged; done and div_by_zero are not pulsed.
- hi/lo outputs always show the committed registers. Intermediate values are never visible.

Test Plan:
- WIDTH=32, MUL_STAGES=2: MULT a=−3 b=7 → edge E0+2 hi=FFFFFFFF lo=FFFFFFEB; done high one cycle; busy high 2 cycles.
- DIVU a=100 b=7 (DIV_BITS=1) → written at E0+33: lo=0000000E hi=00000002. With DIV_BITS=4, written at E0+9 with identical values.
- DIV a=−7 b=2 → lo=FFFFFFFD hi=FFFFFFFF. DIV a=80000000 b=FFFFFFFF → lo=80000000 hi=0.
- DIVU a=5 b=0 → lo=FFFFFFFF hi=00000005; div_by_zero and done pulse together.
- MTHI=FFFFFFFF, MTLO=FFFFFFFF, then MADDU a=1 b=1 → {hi,lo}=0 (wrap). Then MSUB a=1 b=1 → all ones.
- Coverage of stall, flush and reset during DIV:
  - DIV in flight: hilo_read=1 → stall=1; the second start is ignored.
  - flush at iteration 10 → busy drops next edge, HI/LO unchanged, no done.
  - reset low at iteration 5 → all outputs 0 immediately.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit for the MIPS32 execute stage.
// Pipelined multiplier, iterative restoring divider, MTHI/MTLO moves.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hilo_read,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero
);

  localparam int W2   = 2 * WIDTH;
  localparam int N    = WIDTH / DIV_BITS;
  localparam int CMAX = (N > MUL_STAGES) ? N : MUL_STAGES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_sgn;
  logic [1:0]       mul_mode;

  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] div_d;
  logic [WIDTH-1:0] div_a;
  logic             div_qneg;
  logic             div_rneg;
  logic             div_zero;

  logic             is_mul;
  logic             is_div;
  logic             is_mthi;
  logic             is_mtlo;
  logic             op_sgn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [W2-1:0]    ext_a;
  logic [W2-1:0]    ext_b;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    prod_wb;
  logic [W2-1:0]    mul_res;

  logic [WIDTH-1:0] nq;
  logic [WIDTH-1:0] nr;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign is_mul  = (op <= 4'd5);
  assign is_div  = (op == 4'd6) || (op == 4'd7);
  assign is_mthi = (op == 4'd8);
  assign is_mtlo = (op == 4'd9);
  assign op_sgn  = ~op[0];

  assign a_mag = (op_sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (op_sgn && b[WIDTH-1]) ? -b : b;

  assign busy  = (state != S_IDLE);
  assign stall = busy & (start | hilo_read);

  assign ext_a = mul_sgn ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a}
                         : {{WIDTH{1'b0}}, mul_a};
  assign ext_b = mul_sgn ? {{WIDTH{mul_b[WIDTH-1]}}, mul_b}
                         : {{WIDTH{1'b0}}, mul_b};
  assign prod  = ext_a * ext_b;

  if (MUL_STAGES == 1) begin : g_comb
    assign prod_wb = prod;
  end else begin : g_pipe
    logic [W2-1:0] pipe [MUL_STAGES-1];

    // Product pipeline; operands stay latched so the tail is valid at writeback.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < MUL_STAGES - 1; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= prod;
        for (int i = 1; i < MUL_STAGES - 1; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign prod_wb = pipe[MUL_STAGES-2];
  end

  // Accumulate mode selects plain, add or subtract against current HI/LO.
  always_comb begin
    mul_res = prod_wb;
    unique case (mul_mode)
      2'd1:    mul_res = {hi, lo} + prod_wb;
      2'd2:    mul_res = {hi, lo} - prod_wb;
      default: mul_res = prod_wb;
    endcase
  end

  // DIV_BITS restoring steps on magnitudes per iteration.
  always_comb begin
    nq = div_q;
    nr = div_r;
    t  = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      t  = {nr, nq[WIDTH-1]};
      nq = {nq[WIDTH-2:0], 1'b0};
      if (t >= {1'b0, div_d}) begin
        t     = t - {1'b0, div_d};
        nq[0] = 1'b1;
      end
      nr = t[WIDTH-1:0];
    end
  end

  assign q_fix = div_qneg ? -div_q : div_q;
  assign r_fix = div_rneg ? -div_r : div_r;

  // Control FSM plus HI/LO commit and completion pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_sgn     <= 1'b0;
      mul_mode    <= 2'd0;
      div_q       <= '0;
      div_r       <= '0;
      div_d       <= '0;
      div_a       <= '0;
      div_qneg    <= 1'b0;
      div_rneg    <= 1'b0;
      div_zero    <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            unique case (1'b1)
              is_mul: begin
                mul_a    <= a;
                mul_b    <= b;
                mul_sgn  <= op_sgn;
                mul_mode <= op[2:1];
                cnt      <= CW'(MUL_STAGES - 1);
                state    <= S_MUL;
              end
              is_div: begin
                div_q    <= a_mag;
                div_r    <= '0;
                div_d    <= b_mag;
                div_a    <= a;
                div_zero <= (b == '0);
                div_qneg <= op_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                div_rneg <= op_sgn && a[WIDTH-1];
                cnt      <= CW'(N - 1);
                state    <= S_DIV;
              end
              is_mthi: hi <= a;
              is_mtlo: lo <= a;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            {hi, lo} <= mul_res;
            done     <= 1'b1;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DIV: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            div_q <= nq;
            div_r <= nr;
            if (cnt == '0) state <= S_FIX;
            else           cnt   <= cnt - 1'b1;
          end
        end
        S_FIX: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            if (div_zero) begin
              lo          <= '1;
              hi          <= div_a;
              div_by_zero <= 1'b1;
            end else begin
              lo <= q_fix;
              hi <= r_fix;
            end
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed plus random checks of muldiv_unit
// against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W    = 32;
  localparam int MS   = 2;
  localparam int DB   = 1;
  localparam int NDIV = W / DB;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op    = 4'd0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         flush = 1'b0;
  logic         hilo_read = 1'b0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         stall;
  logic         done;
  logic         div_by_zero;

  int nchk = 0;
  int nerr = 0;

  muldiv_unit #(
    .WIDTH(W),
    .MUL_STAGES(MS),
    .DIV_BITS(DB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .flush(flush),
    .hilo_read(hilo_read),
    .hi(hi),
    .lo(lo),
    .busy(busy),
    .stall(stall),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference arithmetic: {div_by_zero, hi, lo}
  function automatic logic [64:0] model_op(input logic [3:0] o,
                                           input logic [31:0] x,
                                           input logic [31:0] y,
                                           input logic [63:0] acc);
    logic [63:0] p;
    int sx;
    int sy;
    if (o <= 4'd5) begin
      if (o[0]) p = {32'b0, x} * {32'b0, y};
      else      p = longint'($signed(x)) * longint'($signed(y));
      case (o)
        4'd0, 4'd1: return {1'b0, p};
        4'd2, 4'd3: return {1'b0, acc + p};
        default:    return {1'b0, acc - p};
      endcase
    end
    if (y == 32'd0) return {1'b1, x, 32'hFFFFFFFF};
    if (o[0]) return {1'b0, x % y, x / y};
    if (x == 32'h80000000 && y == 32'hFFFFFFFF)
      return {1'b0, 32'h0, 32'h80000000};
    sx = x;
    sy = y;
    return {1'b0, sx % sy, sx / sy};
  endfunction

  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic        m_dz   = 1'b0;
  logic [64:0] r_pack = '0;

  // Model: latency countdown to a precomputed result.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (m_left > 0) begin
        if (flush) begin
          m_left <= 0;
        end else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi   <= r_pack[63:32];
            m_lo   <= r_pack[31:0];
            m_done <= 1'b1;
            m_dz   <= r_pack[64];
          end
        end
      end else if (start && !flush) begin
        if (op <= 4'd7) begin
          r_pack <= model_op(op, a, b, {m_hi, m_lo});
          m_left <= (op <= 4'd5) ? MS : NDIV + 1;
        end else if (op == 4'd8) begin
          m_hi <= a;
        end else if (op == 4'd9) begin
          m_lo <= a;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
    chk("busy", 64'(busy), 64'(m_left != 0));
    chk("done", 64'(done), 64'(m_done));
    chk("div_by_zero", 64'(div_by_zero), 64'(m_dz));
    chk("stall", 64'(stall),
        64'((m_left != 0) && (start || hilo_read)));
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(output int lat);
    lat = 0;
    while (m_left != 0 && lat < 200) begin
      lat++;
      step();
    end
    chk("idle_timeout", 64'(m_left), 64'd0);
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, output int lat);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle(lat);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] sv_hi;
    logic [31:0] sv_lo;

    #1 reset = 1'b0;
    repeat (3) step();
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b1;
    step();

    issue(4'd0, 32'hFFFFFFFD, 32'd7, lat);
    chk("mult_lat", 64'(lat), 64'd2);
    chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(lo), 64'hFFFFFFEB);
    chk("mult_done", 64'(done), 64'd1);
    step();
    chk("mult_done_once", 64'(done), 64'd0);

    issue(4'd7, 32'd100, 32'd7, lat);
    chk("divu_lat", 64'(lat), 64'd33);
    chk("divu_lo", 64'(lo), 64'h0000000E);
    chk("divu_hi", 64'(hi), 64'h00000002);

    issue(4'd6, 32'hFFFFFFF9, 32'd2, lat);
    chk("div_neg_lo", 64'(lo), 64'hFFFFFFFD);
    chk("div_neg_hi", 64'(hi), 64'hFFFFFFFF);

    issue(4'd6, 32'h80000000, 32'hFFFFFFFF, lat);
    chk("div_ovf_lo", 64'(lo), 64'h80000000);
    chk("div_ovf_hi", 64'(hi), 64'h0);
    chk("div_ovf_flag", 64'(div_by_zero), 64'd0);

    issue(4'd7, 32'd5, 32'd0, lat);
    chk("dbz_lo", 64'(lo), 64'hFFFFFFFF);
    chk("dbz_hi", 64'(hi), 64'h5);
    chk("dbz_done", 64'(done), 64'd1);
    chk("dbz_flag", 64'(div_by_zero), 64'd1);

    issue(4'd8, 32'hFFFFFFFF, 32'd0, lat);
    issue(4'd9, 32'hFFFFFFFF, 32'd0, lat);
    chk("mthi", 64'(hi), 64'hFFFFFFFF);
    chk("mtlo", 64'(lo), 64'hFFFFFFFF);
    chk("mt_nobusy", 64'(busy), 64'd0);
    issue(4'd3, 32'd1, 32'd1, lat);
    chk("maddu_wrap", {32'(hi), 32'(lo)}, 64'h0);
    issue(4'd4, 32'd1, 32'd1, lat);
    chk("msub_wrap", {32'(hi), 32'(lo)}, 64'hFFFFFFFFFFFFFFFF);

    op = 4'd6;
    a = 32'd1000;
    b = 32'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    hilo_read = 1'b1;
    #1;
    chk("stall_read", 64'(stall), 64'd1);
    start = 1'b1;
    op = 4'd0;
    a = 32'd5;
    b = 32'd5;
    step();
    chk("stall_start", 64'(stall), 64'd1);
    start = 1'b0;
    hilo_read = 1'b0;
    wait_idle(lat);
    chk("stall_div_lo", 64'(lo), 64'd333);
    chk("stall_div_hi", 64'(hi), 64'd1);
    step();

    sv_hi = hi;
    sv_lo = lo;
    op = 4'd7;
    a = 32'd12345;
    b = 32'd17;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi), 64'(sv_hi));
    chk("flush_lo", 64'(lo), 64'(sv_lo));
    repeat (3) begin
      step();
      chk("flush_nodone", 64'(done), 64'd0);
    end

    op = 4'd6;
    a = 32'hFFFFFFCE;
    b = 32'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    #2 reset = 1'b0;
    #1;
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 4) == 0;
      if ($urandom % 8 == 0) op = 4'(8 + $urandom % 8);
      else                   op = 4'($urandom % 8);
      a = pick();
      b = pick();
      flush = ($urandom % 40) == 0;
      hilo_read = ($urandom % 4) == 0;
      step();
    end
    start = 1'b0;
    flush = 1'b0;
    hilo_read = 1'b0;
    repeat (50) step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
